// File: rtl/video_line_sequencer_pkg.sv
// video_line_sequencer_pkg: shared FSM encoding, counter widths and pixel-width legality for the line sequencer
// Contents: seq_state_t FSM encoding, counter width localparams, dsize_legal() helper.
package video_line_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_LINE,
        ST_IN_LINE,
        ST_DROP_LINE
    } seq_state_t;

    localparam int PIX_CNT_BITS  = 24;
    localparam int LINE_CNT_BITS = 12;
    localparam int DROP_CNT_BITS = 16;

    function automatic bit dsize_legal(int dsize);
        return dsize == 8 || dsize == 16 || dsize == 24 || dsize == 32;
    endfunction

endpackage

// File: rtl/video_line_sequencer_edge_detect.sv
// edge_detect: registers the previous sample of a level and flags its rising and falling edges
// Ports: clk, rst_n (async active-low); d level in; rise/fall edge flags valid in the cycle d changes.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic d_q;

    // Previous sample resets high so a level already high at reset release is not taken as a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b1;
        else        d_q <= d;
    end

    // Edges are decoded against the registered history so the consumer can react in the same cycle.
    assign rise = d & ~d_q;
    assign fall = ~d & d_q;

endmodule

// File: rtl/video_line_sequencer.sv
// video_line_sequencer: turns a vsync/de pixel stream into addressed, length-tagged line bursts for a video DMA writer
// Ports: stream_clk, stream_rst_n (async active-low); vsync/de/indata incoming video;
//   frame_baseaddr/line_stride/line_width/frame_height frame geometry sampled on vsync rise;
//   ds_ready downstream can take a new line; stream_in_sof/vld/data/baseaddr/length line bursts out;
//   frame_done end-of-frame pulse, drop_cnt saturating dropped-line count, len_err sticky length mismatch.
module video_line_sequencer
    import video_line_sequencer_pkg::*;
#(
    parameter int ADDR_BITS = 25,
    parameter int DSIZE     = 24
) (
    input  logic                     stream_clk,
    input  logic                     stream_rst_n,
    input  logic                     vsync,
    input  logic                     de,
    input  logic [DSIZE-1:0]         indata,
    input  logic [ADDR_BITS-1:0]     frame_baseaddr,
    input  logic [ADDR_BITS-1:0]     line_stride,
    input  logic [PIX_CNT_BITS-1:0]  line_width,
    input  logic [LINE_CNT_BITS-1:0] frame_height,
    input  logic                     ds_ready,
    output logic                     stream_in_sof,
    output logic                     stream_in_vld,
    output logic [DSIZE-1:0]         stream_in_data,
    output logic [ADDR_BITS-1:0]     stream_in_baseaddr,
    output logic [PIX_CNT_BITS-1:0]  stream_in_length,
    output logic                     frame_done,
    output logic [DROP_CNT_BITS-1:0] drop_cnt,
    output logic                     len_err
);

    if (!dsize_legal(DSIZE)) begin : g_bad_dsize
        $error("video_line_sequencer: DSIZE must be 8, 16, 24 or 32");
    end

    logic vsync_rise, vsync_fall_unused, de_rise, de_fall;

    edge_detect u_vsync_edge (
        .clk  (stream_clk),
        .rst_n(stream_rst_n),
        .d    (vsync),
        .rise (vsync_rise),
        .fall (vsync_fall_unused)
    );

    edge_detect u_de_edge (
        .clk  (stream_clk),
        .rst_n(stream_rst_n),
        .d    (de),
        .rise (de_rise),
        .fall (de_fall)
    );

    seq_state_t               state;
    logic [ADDR_BITS-1:0]     line_addr, stride_q;
    logic [PIX_CNT_BITS-1:0]  width_q, pix_cnt;
    logic [LINE_CNT_BITS-1:0] height_q, line_cnt, line_next;
    logic                     line_open, in_line, last_line;
    logic [ADDR_BITS-1:0]     start_addr;
    logic [PIX_CNT_BITS-1:0]  start_len;

    // A vsync in this cycle makes the freshly presented geometry govern a coincident de rise.
    assign start_addr = vsync_rise ? frame_baseaddr : line_addr;
    assign start_len  = vsync_rise ? line_width : width_q;
    assign line_open  = vsync_rise || state == ST_WAIT_LINE;
    assign in_line    = state == ST_IN_LINE;
    assign line_next  = line_cnt + 12'd1;
    assign last_line  = line_next == height_q;

    always_ff @(posedge stream_clk or negedge stream_rst_n) begin
        if (!stream_rst_n) begin
            state              <= ST_IDLE;
            line_addr          <= '0;
            stride_q           <= '0;
            width_q            <= '0;
            height_q           <= '0;
            line_cnt           <= '0;
            pix_cnt            <= '0;
            stream_in_sof      <= 1'b0;
            stream_in_vld      <= 1'b0;
            stream_in_data     <= '0;
            stream_in_baseaddr <= '0;
            stream_in_length   <= '0;
            frame_done         <= 1'b0;
            drop_cnt           <= '0;
            len_err            <= 1'b0;
        end else begin
            stream_in_sof <= 1'b0;
            frame_done    <= 1'b0;
            // New frame: latch geometry and abandon whatever line was in flight without a length check.
            if (vsync_rise) begin
                line_addr     <= frame_baseaddr;
                stride_q      <= line_stride;
                width_q       <= line_width;
                height_q      <= frame_height;
                line_cnt      <= '0;
                len_err       <= 1'b0;
                stream_in_vld <= 1'b0;
                state         <= ST_WAIT_LINE;
            end
            if (de_rise && line_open) begin
                if (ds_ready) begin
                    state              <= ST_IN_LINE;
                    stream_in_sof      <= 1'b1;
                    stream_in_vld      <= 1'b1;
                    stream_in_data     <= indata;
                    stream_in_baseaddr <= start_addr;
                    stream_in_length   <= start_len;
                    pix_cnt            <= 24'd1;
                end else begin
                    state    <= ST_DROP_LINE;
                    drop_cnt <= drop_cnt + {15'd0, ~&drop_cnt};
                end
            end else if (!vsync_rise && (in_line || state == ST_DROP_LINE)) begin
                if (de_fall) begin
                    line_addr     <= line_addr + stride_q;
                    line_cnt      <= line_next;
                    frame_done    <= last_line;
                    state         <= last_line ? ST_IDLE : ST_WAIT_LINE;
                    stream_in_vld <= 1'b0;
                    if (in_line && pix_cnt != width_q) len_err <= 1'b1;
                end else if (in_line) begin
                    stream_in_vld  <= 1'b1;
                    stream_in_data <= indata;
                    pix_cnt        <= pix_cnt + {23'd0, ~&pix_cnt};
                end
            end
        end
    end

endmodule

// File: tb/tb_video_line_sequencer.sv
// tb_video_line_sequencer: scoreboard bench with a frame/line-level reference model for video_line_sequencer
module tb_video_line_sequencer;

    localparam int AB = 25;
    localparam int DS = 24;

    logic          clk = 1'b0, rst_n = 1'b1, vsync = 1'b0, de = 1'b0, ds_ready = 1'b0;
    logic [DS-1:0] indata = '0;
    logic [AB-1:0] frame_baseaddr = '0, line_stride = '0;
    logic [23:0]   line_width = 24'd1;
    logic [11:0]   frame_height = 12'd1;
    logic          stream_in_sof, stream_in_vld, frame_done, len_err;
    logic [DS-1:0] stream_in_data;
    logic [AB-1:0] stream_in_baseaddr;
    logic [23:0]   stream_in_length;
    logic [15:0]   drop_cnt;

    video_line_sequencer #(.ADDR_BITS(AB), .DSIZE(DS)) dut (
        .stream_clk        (clk),
        .stream_rst_n      (rst_n),
        .vsync             (vsync),
        .de                (de),
        .indata            (indata),
        .frame_baseaddr    (frame_baseaddr),
        .line_stride       (line_stride),
        .line_width        (line_width),
        .frame_height      (frame_height),
        .ds_ready          (ds_ready),
        .stream_in_sof     (stream_in_sof),
        .stream_in_vld     (stream_in_vld),
        .stream_in_data    (stream_in_data),
        .stream_in_baseaddr(stream_in_baseaddr),
        .stream_in_length  (stream_in_length),
        .frame_done        (frame_done),
        .drop_cnt          (drop_cnt),
        .len_err           (len_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sof;
        logic [DS-1:0] data;
        logic [AB-1:0] addr;
        logic [23:0]   len;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_b;
    int    checks = 0, failures = 0, done_seen = 0, m_done_exp = 0;
    int    m_drop = 0, m_k = 0;
    bit    m_active = 0, m_len_err = 0;
    logic [AB-1:0] m_base = '0, m_stride = '0;
    logic [23:0]   m_width = '0;
    logic [11:0]   m_height = '0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Line k of the current frame lives at base + k*stride, wrapped to the address width.
    function automatic logic [AB-1:0] exp_addr();
        logic [63:0] a;
        a = 64'(m_base) + 64'(m_k) * 64'(m_stride);
        return a[AB-1:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            chk("sof_needs_vld", {63'd0, stream_in_sof & ~stream_in_vld}, 64'd0);
            if (stream_in_vld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_vld actual=1 required=0 data=%0h addr=%0h at %0t", stream_in_data, stream_in_baseaddr, $time);
                end else begin
                    mon_b = exp_q.pop_front();
                    chk("sof", {63'd0, stream_in_sof}, {63'd0, mon_b.sof});
                    chk("data", 64'(stream_in_data), 64'(mon_b.data));
                    chk("baseaddr", 64'(stream_in_baseaddr), 64'(mon_b.addr));
                    chk("length", 64'(stream_in_length), 64'(mon_b.len));
                end
            end
            if (frame_done) done_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_vsync();
        m_active  = 1;
        m_base    = frame_baseaddr;
        m_stride  = line_stride;
        m_width   = line_width;
        m_height  = frame_height;
        m_k       = 0;
        m_len_err = 0;
    endtask

    task automatic set_params(logic [AB-1:0] b, logic [AB-1:0] s, logic [23:0] w, logic [11:0] h);
        frame_baseaddr = b;
        line_stride    = s;
        line_width     = w;
        frame_height   = h;
    endtask

    // Geometry inputs change freely outside vsync; the DUT must not pick them up.
    task automatic scramble();
        set_params($urandom, $urandom, 24'($urandom_range(1, 10)), 12'($urandom_range(1, 4)));
    endtask

    task automatic start_frame(logic [AB-1:0] b, logic [AB-1:0] s, logic [23:0] w, logic [11:0] h);
        set_params(b, s, w, h);
        vsync = 1;
        model_vsync();
        tick();
        vsync = 0;
        scramble();
        tick();
    endtask

    // One de run of npix pixels; vs_at >= 0 raises vsync on that pixel (0 = same cycle as the de rise).
    task automatic send_line(int npix, bit rdy, int gap, int vs_at);
        bit live, abort;
        live  = 0;
        abort = 0;
        for (int i = 0; i < npix; i++) begin
            vsync = (i == vs_at);
            if (i == vs_at) begin
                model_vsync();
                abort = (i != 0);
            end
            if (i == 0) begin
                ds_ready = rdy;
                live = m_active && rdy;
                if (m_active && !rdy) m_drop = (m_drop < 65535) ? m_drop + 1 : m_drop;
            end else ds_ready = 1'($urandom_range(0, 1));
            de = 1;
            indata = DS'($urandom);
            if (live && !abort) exp_q.push_back('{sof: (i == 0), data: indata, addr: exp_addr(), len: m_width});
            tick();
            if (i == vs_at) scramble();
        end
        vsync = 0;
        de = 0;
        if (m_active && !abort) begin
            if (live && npix != int'(m_width)) m_len_err = 1;
            m_k++;
            if (m_k == int'(m_height)) begin
                m_active = 0;
                m_done_exp++;
            end
        end
        for (int g = 0; g < gap; g++) begin
            ds_ready = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    task automatic check_status(string tag);
        tick();
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
        chk({tag, "_len_err"}, {63'd0, len_err}, {63'd0, m_len_err});
        chk({tag, "_frame_done_count"}, 64'(done_seen), 64'(m_done_exp));
        chk({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_sof"}, {63'd0, stream_in_sof}, 64'd0);
        chk({tag, "_vld"}, {63'd0, stream_in_vld}, 64'd0);
        chk({tag, "_data"}, 64'(stream_in_data), 64'd0);
        chk({tag, "_baseaddr"}, 64'(stream_in_baseaddr), 64'd0);
        chk({tag, "_length"}, 64'(stream_in_length), 64'd0);
        chk({tag, "_frame_done"}, {63'd0, frame_done}, 64'd0);
        chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
        chk({tag, "_len_err"}, {63'd0, len_err}, 64'd0);
    endtask

    initial begin
        int w, h, nl, np, vs;
        #1 rst_n = 0;
        #2 chk_zero("reset");
        repeat (3) tick();
        rst_n = 1;
        repeat (3) tick();

        // Basic frame, then extra lines after frame end that must be ignored.
        start_frame(25'h100, 25'h40, 24'd8, 12'd3);
        for (int l = 0; l < 3; l++) send_line(8, 1, 2, -1);
        send_line(5, 1, 2, -1);
        send_line(5, 0, 2, -1);
        check_status("basic");

        // Downstream busy at line 2.
        start_frame(25'h200, 25'h40, 24'd8, 12'd3);
        send_line(8, 1, 2, -1);
        send_line(8, 0, 2, -1);
        send_line(8, 1, 2, -1);
        check_status("drop");

        // Short line flags len_err; next vsync clears it.
        start_frame(25'h1000, 25'h100, 24'd8, 12'd2);
        send_line(7, 1, 2, -1);
        check_status("short");
        start_frame(25'h2000, 25'h100, 24'd8, 12'd1);
        check_status("cleared");
        send_line(9, 1, 2, -1);
        check_status("long");

        // vsync mid-line at pixel 4, then first line of the new frame.
        start_frame(25'h300, 25'h10, 24'd8, 12'd3);
        set_params(25'h5000, 25'h20, 24'd6, 12'd2);
        send_line(8, 1, 2, 4);
        send_line(6, 1, 2, -1);
        send_line(6, 1, 2, -1);
        check_status("abort");

        // vsync and de rise in the same cycle.
        set_params(25'h4000, 25'h20, 24'd4, 12'd2);
        send_line(4, 1, 2, 0);
        send_line(4, 1, 2, -1);
        check_status("same_cycle");

        // Address wrap.
        start_frame(25'h1FFFFC0, 25'h80, 24'd4, 12'd2);
        send_line(4, 1, 2, -1);
        send_line(4, 1, 2, -1);
        check_status("wrap");

        // Asynchronous reset in the middle of a line.
        start_frame(25'h500, 25'h40, 24'd8, 12'd3);
        ds_ready = 1;
        for (int i = 0; i < 3; i++) begin
            de = 1;
            indata = DS'($urandom);
            exp_q.push_back('{sof: (i == 0), data: indata, addr: exp_addr(), len: m_width});
            tick();
            ds_ready = 0;
        end
        #2 rst_n = 0;
        #1 chk_zero("midline_reset");
        exp_q.delete();
        m_active = 0;
        m_drop = 0;
        m_len_err = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
        de = 0;
        tick();
        send_line(6, 1, 2, -1);
        send_line(6, 0, 2, -1);
        check_status("after_reset");

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            w = $urandom_range(1, 10);
            h = $urandom_range(1, 4);
            start_frame(AB'($urandom), AB'($urandom), 24'(w), 12'(h));
            nl = h + $urandom_range(0, 2);
            for (int l = 0; l < nl; l++) begin
                np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, w + 2) : w;
                vs = (np > 1 && $urandom_range(0, 11) == 0) ? $urandom_range(1, np - 1) : -1;
                send_line(np, $urandom_range(0, 3) != 0, $urandom_range(1, 3), vs);
            end
            check_status("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
